// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between an initiator and the memory responder
interface mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding word memory responder with fixed response latency
module mem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input logic           clock,
   input logic           reset,
   mem_responder_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [3:0]      count;
   logic            cap_write;
   logic [31:0]     cap_addr;
   logic [31:0]     cap_wdata;
   logic [3:0]      cap_be;
   logic            resp_valid;
   logic            resp_error;
   logic [31:0]     resp_rdata;
   logic [31:0]     mem [DEPTH];

   logic            ready;
   logic            accept;
   logic            enter_resp;
   logic            acc_write;
   logic [31:0]     acc_addr;
   logic [31:0]     acc_wdata;
   logic [3:0]      acc_be;
   logic            acc_error;
   logic [ADDR_WIDTH-1:0] acc_index;
   logic [31:0]     next_rdata;

   assign ready  = (state == IDLE) && !reset;
   assign accept = bus.req_valid && ready;

   // With LATENCY=1 the access happens on the accept edge itself, so the live bus fields are used there.
   always_comb begin
      acc_write = cap_write;
      acc_addr  = cap_addr;
      acc_wdata = cap_wdata;
      acc_be    = cap_be;
      if (state == IDLE) begin
         acc_write = bus.req_write;
         acc_addr  = bus.req_addr;
         acc_wdata = bus.req_wdata;
         acc_be    = bus.req_be;
      end
   end

   assign acc_error  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_WIDTH+2] != '0);
   assign acc_index  = acc_addr[ADDR_WIDTH+1:2];
   assign next_rdata = (acc_error || acc_write) ? 32'd0 : mem[acc_index];
   assign enter_resp = ((state == IDLE) && accept && (LATENCY == 1)) ||
                       ((state == WAIT) && (count == 4'd0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 4'd0;
         cap_write  <= 1'b0;
         cap_addr   <= 32'd0;
         cap_wdata  <= 32'd0;
         cap_be     <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_write <= bus.req_write;
                  cap_addr  <= bus.req_addr;
                  cap_wdata <= bus.req_wdata;
                  cap_be    <= bus.req_be;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     count <= 4'(LATENCY - 2);
                  end
               end
            end
            WAIT: begin
               if (count == 4'd0) begin
                  state <= RESP;
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_error <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_rdata <= next_rdata;
            resp_error <= acc_error;
         end
      end
   end

   // Storage is never cleared; a store lands on the same edge that raises resp_valid.
   always_ff @(posedge clock) begin
      if (!reset && enter_resp && acc_write && !acc_error) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_index][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign bus.req_ready  = ready;
   assign bus.resp_valid = resp_valid;
   assign bus.resp_rdata = resp_rdata;
   assign bus.resp_error = resp_error;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against a word-array model
`timescale 1ns/1ps
module tb_mem_responder;
   localparam int AW = 8;
   localparam int NW = 256;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mem_responder_if bus0 ();
   mem_responder_if bus1 ();

   mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut_a (.clock(clock), .reset(reset), .bus(bus0));
   mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut_b (.clock(clock), .reset(reset), .bus(bus1));

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] ref_a [NW];
   logic [31:0] ref_b [NW];

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(4 * NW));
   endfunction

   // Reference: a word array; stores merge enabled bytes, loads return the whole word.
   function automatic void model(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] be, output logic [31:0] rd, output bit err);
      logic [31:0] mask;
      logic [31:0] old;
      err = addr_bad(a);
      rd = 32'd0;
      mask = 32'd0;
      if (!err) begin
         old = sel ? ref_b[a / 4] : ref_a[a / 4];
         if (w) begin
            for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
            if (sel) ref_b[a / 4] = (old & ~mask) | (d & mask);
            else     ref_a[a / 4] = (old & ~mask) | (d & mask);
         end else begin
            rd = old;
         end
      end
   endfunction

   // Drives one transaction on bus0 with resp_ready held high; starts and ends 1ns after an edge.
   task automatic drive_a(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output logic [31:0] rd, output bit err, output int lat,
                          output bit post_valid, output bit post_ready);
      bit pre;
      bit got;
      got = 1'b0;
      lat = 99;
      bus0.req_write = w; bus0.req_addr = a; bus0.req_wdata = d; bus0.req_be = be;
      bus0.req_valid = 1'b1; bus0.resp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pre = bus0.req_ready;
         @(posedge clock); #1;
         if (pre) begin got = 1'b1; break; end
      end
      bus0.req_valid = 1'b0;
      if (got) begin
         lat = 1;
         while (!bus0.resp_valid && lat < 20) begin @(posedge clock); #1; lat++; end
      end
      rd = bus0.resp_rdata;
      err = bus0.resp_error;
      @(posedge clock); #1;
      post_valid = bus0.resp_valid;
      post_ready = bus0.req_ready;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0: return (32'($urandom_range(0, NW - 1)) * 4) | 32'($urandom_range(1, 3));
         1: return (32'($urandom_range(1, 1000)) << 10) | (32'($urandom_range(0, NW - 1)) * 4);
         default: return 32'($urandom_range(0, NW - 1)) * 4;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready} !== 35'd0) begin
         n_fail++; $display("FAIL reset_outputs_a got v=%b e=%b d=%h r=%b want all 0",
                            bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready);
      end
      n_cmp++;
      if ({bus1.resp_valid, bus1.resp_error, bus1.resp_rdata, bus1.req_ready} !== 35'd0) begin
         n_fail++; $display("FAIL reset_outputs_b got v=%b e=%b d=%h r=%b want all 0",
                            bus1.resp_valid, bus1.resp_error, bus1.resp_rdata, bus1.req_ready);
      end
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus0.req_ready, bus1.req_ready} !== 2'b11) begin
         n_fail++; $display("FAIL first_cycle_ready got %b%b want 11", bus0.req_ready, bus1.req_ready);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_fill();
      logic [31:0] d, rd, erd;
      bit err, eerr, pv, pr;
      int lat;
      for (int w = 0; w < NW; w++) begin
         d = $urandom;
         drive_a(1'b1, 32'(w * 4), d, 4'hF, rd, err, lat, pv, pr);
         model(1'b0, 1'b1, 32'(w * 4), d, 4'hF, erd, eerr);
         n_cmp++;
         if (lat !== 2) begin n_fail++; $display("FAIL fill_latency word=%0d got=%0d want=2", w, lat); end
         n_cmp++;
         if ({err, rd, pv, pr} !== {eerr, erd, 2'b01}) begin
            n_fail++; $display("FAIL fill_resp word=%0d got e=%b d=%h pv=%b pr=%b want e=%b d=%h pv=0 pr=1",
                               w, err, rd, pv, pr, eerr, erd);
         end
      end
   endtask

   task automatic test_basic();
      logic [31:0] rd, erd;
      bit err, eerr, pv, pr;
      int lat;
      drive_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, pv, pr);
      model(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eerr);
      n_cmp++;
      if (lat !== 2) begin n_fail++; $display("FAIL basic_store_latency got=%0d want=2", lat); end
      n_cmp++;
      if ({err, rd} !== 33'd0) begin n_fail++; $display("FAIL basic_store_resp got e=%b d=%h want 0/0", err, rd); end
      n_cmp++;
      if ({pv, pr} !== 2'b01) begin n_fail++; $display("FAIL basic_after_handshake got pv=%b pr=%b want 0 1", pv, pr); end
      drive_a(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, pv, pr);
      n_cmp++;
      if ({err, rd} !== {1'b0, 32'hDEADBEEF}) begin
         n_fail++; $display("FAIL basic_load got e=%b d=%h want 0/deadbeef", err, rd);
      end
   endtask

   task automatic test_byte_enable();
      logic [31:0] rd, erd, a, d;
      logic [3:0] be;
      bit err, eerr, pv, pr, w;
      int lat;
      drive_a(1'b1, 32'h10, 32'h00005500, 4'b0010, rd, err, lat, pv, pr);
      model(1'b0, 1'b1, 32'h10, 32'h00005500, 4'b0010, erd, eerr);
      drive_a(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, pv, pr);
      n_cmp++;
      if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL be_partial_store got=%h want=dead55ef", rd); end
      drive_a(1'b1, 32'h10, $urandom, 4'b0000, rd, err, lat, pv, pr);
      n_cmp++;
      if ({lat, err, rd} !== {32'd2, 1'b0, 32'd0}) begin
         n_fail++; $display("FAIL be_zero_complete got lat=%0d e=%b d=%h want 2/0/0", lat, err, rd);
      end
      drive_a(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, pv, pr);
      n_cmp++;
      if (rd !== 32'hDEAD55EF) begin n_fail++; $display("FAIL be_zero_unchanged got=%h want=dead55ef", rd); end
      for (int k = 0; k < 80; k++) begin
         w = 1'($urandom_range(0, 1));
         a = rand_addr();
         d = $urandom;
         be = 4'($urandom);
         drive_a(w, a, d, be, rd, err, lat, pv, pr);
         model(1'b0, w, a, d, be, erd, eerr);
         n_cmp++;
         if ({lat, err, rd, pv, pr} !== {32'd2, eerr, erd, 2'b01}) begin
            n_fail++; $display("FAIL random_txn k=%0d w=%b a=%h got lat=%0d e=%b d=%h pv=%b pr=%b want 2 e=%b d=%h 0 1",
                               k, w, a, lat, err, rd, pv, pr, eerr, erd);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      bit err, pv, pr;
      int lat;
      drive_a(1'b0, 32'h13, 32'h0, 4'hF, rd, err, lat, pv, pr);
      n_cmp++;
      if ({err, rd} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL err_misaligned got e=%b d=%h want 1/0", err, rd); end
      drive_a(1'b0, 32'h400, 32'h0, 4'hF, rd, err, lat, pv, pr);
      n_cmp++;
      if ({err, rd} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL err_out_of_range got e=%b d=%h want 1/0", err, rd); end
      drive_a(1'b1, 32'h400, $urandom, 4'hF, rd, err, lat, pv, pr);
      n_cmp++;
      if ({lat, err, rd} !== {32'd2, 1'b1, 32'd0}) begin
         n_fail++; $display("FAIL err_store_resp got lat=%0d e=%b d=%h want 2/1/0", lat, err, rd);
      end
      drive_a(1'b1, 32'h11, $urandom, 4'hF, rd, err, lat, pv, pr);
      for (int w = 0; w < NW; w++) begin
         drive_a(1'b0, 32'(w * 4), 32'h0, 4'h0, rd, err, lat, pv, pr);
         n_cmp++;
         if ({err, rd} !== {1'b0, ref_a[w]}) begin
            n_fail++; $display("FAIL err_sweep word=%0d got e=%b d=%h want 0/%h", w, err, rd, ref_a[w]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd, held;
      bit err, pv, pr;
      int lat, waited;
      bus0.req_write = 1'b0; bus0.req_addr = 32'h10; bus0.req_be = 4'hF; bus0.req_wdata = 32'h0;
      bus0.req_valid = 1'b1; bus0.resp_ready = 1'b0;
      @(posedge clock); #1;
      bus0.req_write = 1'b1; bus0.req_addr = 32'h30; bus0.req_wdata = ~ref_a[12];
      waited = 0;
      while (!bus0.resp_valid && waited < 20) begin @(posedge clock); #1; waited++; end
      held = ref_a[4];
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if ({bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready} !== {2'b10, held, 1'b0}) begin
            n_fail++; $display("FAIL hold_stable k=%0d got v=%b e=%b d=%h r=%b want 1 0 %h 0", k,
                               bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready, held);
         end
         @(posedge clock); #1;
      end
      bus0.req_valid = 1'b0;
      bus0.resp_ready = 1'b1;
      @(posedge clock); #1;
      n_cmp++;
      if ({bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready} !== {34'd0, 1'b1}) begin
         n_fail++; $display("FAIL hold_release got v=%b e=%b d=%h r=%b want 0 0 0 1",
                            bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready);
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         n_cmp++;
         if (bus0.resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_single_resp k=%0d got v=%b want 0", k, bus0.resp_valid); end
      end
      drive_a(1'b0, 32'h30, 32'h0, 4'h0, rd, err, lat, pv, pr);
      n_cmp++;
      if (rd !== ref_a[12]) begin n_fail++; $display("FAIL hold_ignored_store got=%h want=%h", rd, ref_a[12]); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd, d;
      bit err, eerr, pv, pr;
      int lat, waited;
      if (ref_a[8] === 32'h12345678) begin
         drive_a(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, err, lat, pv, pr);
         model(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, erd, eerr);
      end
      bus0.req_write = 1'b1; bus0.req_addr = 32'h20; bus0.req_wdata = 32'h12345678; bus0.req_be = 4'hF;
      bus0.req_valid = 1'b1; bus0.resp_ready = 1'b1;
      @(posedge clock); #1;
      bus0.req_valid = 1'b0;
      n_cmp++;
      if ({bus0.req_ready, bus0.resp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL wait_state got r=%b v=%b want 0 0", bus0.req_ready, bus0.resp_valid);
      end
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready} !== 35'd0) begin
         n_fail++; $display("FAIL reset_in_wait_outputs got v=%b e=%b d=%h r=%b want all 0",
                            bus0.resp_valid, bus0.resp_error, bus0.resp_rdata, bus0.req_ready);
      end
      @(posedge clock); @(posedge clock);
      #3 reset = 1'b0;
      #1;
      n_cmp++;
      if (bus0.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got=%b want=1", bus0.req_ready); end
      @(posedge clock); #1;
      drive_a(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, pv, pr);
      n_cmp++;
      if (rd !== ref_a[8]) begin n_fail++; $display("FAIL reset_in_wait_dropped got=%h want=%h", rd, ref_a[8]); end

      d = $urandom;
      bus0.req_write = 1'b1; bus0.req_addr = 32'h24; bus0.req_wdata = d; bus0.req_be = 4'hF;
      bus0.req_valid = 1'b1; bus0.resp_ready = 1'b0;
      @(posedge clock); #1;
      bus0.req_valid = 1'b0;
      waited = 0;
      while (!bus0.resp_valid && waited < 20) begin @(posedge clock); #1; waited++; end
      model(1'b0, 1'b1, 32'h24, d, 4'hF, erd, eerr);
      #1 reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus0.resp_valid, bus0.req_ready} !== 2'b00) begin
         n_fail++; $display("FAIL reset_in_resp_outputs got v=%b r=%b want 0 0", bus0.resp_valid, bus0.req_ready);
      end
      @(posedge clock);
      #4 reset = 1'b0;
      @(posedge clock); #1;
      drive_a(1'b0, 32'h24, 32'h0, 4'h0, rd, err, lat, pv, pr);
      n_cmp++;
      if (rd !== d) begin n_fail++; $display("FAIL reset_in_resp_kept got=%h want=%h", rd, d); end
   endtask

   task automatic test_back_to_back();
      bit w_arr [16];
      logic [31:0] a_arr [16];
      logic [31:0] d_arr [16];
      logic [31:0] erd;
      bit eerr, pre;
      int idx, last_acc;
      for (int i = 0; i < 16; i++) begin
         w_arr[i] = (i < 8);
         a_arr[i] = 32'((i % 8) * 4);
         d_arr[i] = $urandom;
      end
      idx = 0;
      last_acc = -10;
      bus1.resp_ready = 1'b1;
      bus1.req_write = w_arr[0]; bus1.req_addr = a_arr[0]; bus1.req_wdata = d_arr[0]; bus1.req_be = 4'hF;
      bus1.req_valid = 1'b1;
      for (int c = 0; c < 40 && idx < 16; c++) begin
         pre = bus1.req_ready;
         @(posedge clock); #1;
         if (pre) begin
            model(1'b1, w_arr[idx], a_arr[idx], d_arr[idx], 4'hF, erd, eerr);
            n_cmp++;
            if ({bus1.resp_valid, bus1.req_ready, bus1.resp_error, bus1.resp_rdata} !== {2'b10, eerr, erd}) begin
               n_fail++; $display("FAIL b2b_resp idx=%0d got v=%b r=%b e=%b d=%h want 1 0 %b %h", idx,
                                  bus1.resp_valid, bus1.req_ready, bus1.resp_error, bus1.resp_rdata, eerr, erd);
            end
            if (idx > 0) begin
               n_cmp++;
               if (c - last_acc !== 2) begin n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d want=2", idx, c - last_acc); end
            end
            last_acc = c;
            idx++;
            if (idx < 16) begin
               bus1.req_write = w_arr[idx]; bus1.req_addr = a_arr[idx]; bus1.req_wdata = d_arr[idx];
            end else begin
               bus1.req_valid = 1'b0;
            end
         end else begin
            n_cmp++;
            if ({bus1.resp_valid, bus1.req_ready} !== 2'b01) begin
               n_fail++; $display("FAIL b2b_handshake c=%0d got v=%b r=%b want 0 1", c, bus1.resp_valid, bus1.req_ready);
            end
         end
      end
      n_cmp++;
      if (idx !== 16) begin n_fail++; $display("FAIL b2b_count got=%0d want=16", idx); end
      @(posedge clock); #1;
      bus1.resp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
      bus0.req_be = 4'h0; bus0.resp_ready = 1'b0;
      bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
      bus1.req_be = 4'h0; bus1.resp_ready = 1'b0;
      for (int i = 0; i < NW; i++) ref_b[i] = 32'h0;
      test_reset();
      test_fill();
      test_basic();
      test_byte_enable();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
